store_write_unit: RTL

- Multicycle store path: takes a register value and writes it to word-addressed memory as a word, halfword or byte. Moves data in the opposite direction from the register-load muxes.
- Sub-word stores use a read-modify-write sequence. Word stores write directly.
- Sits between the control unit and the memory port. It owns the memory address, data and write-enable signals while busy.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/store_merge.sv | 23 ++
 rtl/store_write_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the store path: size codes, FSM states and the default datapath width.
package cpu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StDone,
    StErr
  } store_state_e;

endpackage

// File: rtl/store_merge.sv
// Combinational little-endian lane merge: overlays the low bits of new_data onto old_word.
module store_merge
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [1:0]        size,
  input  logic [1:0]        addr,
  output logic [DATA_W-1:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    unique case (size)
      SZ_BYTE: merged_word[{addr, 3'b000} +: 8]     = new_data[7:0];
      SZ_HALF: merged_word[{addr[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged_word = new_data;
    endcase
  end

endmodule

// File: rtl/store_write_unit.sv
// Multicycle store engine: word stores write directly, sub-word stores read-modify-write.
module store_write_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_RD_LATENCY = 1,
  parameter int unsigned DATA_W         = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_size,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] CntLoad = 3'(MEM_RD_LATENCY - 1);

  store_state_e      state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] merged;

  store_merge #(
    .DATA_W(DATA_W)
  ) u_merge (
    .old_word   (mem_rdata),
    .new_data   (data_q),
    .size       (size_q),
    .addr       (lane_q),
    .merged_word(merged)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    lane_d  = lane_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          size_d = store_size;
          lane_d = address[1:0];
          data_d = write_data;
          if (!(store_size inside {SZ_WORD, SZ_HALF, SZ_BYTE}) ||
              (store_size == SZ_HALF && address[0])) begin
            state_d = StErr;
          end else begin
            // No carry into the word address: the low two bits are simply dropped.
            addr_d = {address[DATA_W-1:2], 2'b00};
            if (store_size == SZ_WORD) begin
              wdata_d = write_data;
              state_d = StWrite;
            end else begin
              state_d = StRead;
            end
          end
        end
      end
      StRead: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          wdata_d = merged;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWrite: state_d = StDone;
      StDone: begin
        addr_d  = '0;
        wdata_d = '0;
        state_d = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      size_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset cuts them at once.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = (state_q == StWrite);
  assign busy      = state_q inside {StRead, StWait, StWrite, StDone};
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);

endmodule
